// File: rtl/fpu_norm_arbiter_pkg.sv
// fpu_norm_arbiter_pkg
// Shared FPU types for the normalizer arbiter and its users.
//   fpuOp_t         : operation carried with each significand request
//   normSrc_t       : which requester produced a normalized result
//   OVF_COUNT_MAX   : saturation value of the overflow result counter
//   other_src()     : the requester that is not the given one
package fpu_norm_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } fpuOp_t;

    typedef enum logic {
        SRC_ADD = 1'b0,
        SRC_MUL = 1'b1
    } normSrc_t;

    localparam logic [7:0] OVF_COUNT_MAX = 8'hFF;

    function automatic normSrc_t other_src(input normSrc_t src);
        return (src == SRC_ADD) ? SRC_MUL : SRC_ADD;
    endfunction

endpackage

// File: rtl/fpu_norm_arbiter_if.sv
// fpu_norm_arbiter_if
// Bundles the two requester handshakes and the result/status outputs of the
// shared normalizer arbiter.
//   reqValid/reqReady[1:0]  : per-requester valid/ready (index 0 = add/sub, 1 = mul)
//   reqOp/reqSig/reqExp[2]  : per-requester operation, extended significand, adjusted exponent
//   outValid/outReady       : result stage handshake
//   outSig/outExp/outV      : normalized significand, exponent, exponent overflow flag
//   outSrc                  : requester that produced the held result
//   ovfCount                : saturating count of delivered results with outV set
// Modports: slave = the arbiter, master = requesters plus result consumer.
interface fpu_norm_arbiter_if
    import fpu_norm_arbiter_pkg::*;
#(
    parameter int EXP_WIDTH = 5,
    parameter int SIG_WIDTH = 10
);

    logic [1:0]           reqValid;
    logic [1:0]           reqReady;
    fpuOp_t               reqOp  [2];
    logic [SIG_WIDTH:0]   reqSig [2];
    logic [EXP_WIDTH-1:0] reqExp [2];

    logic                 outValid;
    logic                 outReady;
    logic [SIG_WIDTH:0]   outSig;
    logic [EXP_WIDTH-1:0] outExp;
    logic                 outV;
    normSrc_t             outSrc;
    logic [7:0]           ovfCount;

    modport slave (
        input  reqValid, reqOp, reqSig, reqExp, outReady,
        output reqReady, outValid, outSig, outExp, outV, outSrc, ovfCount
    );

    modport master (
        output reqValid, reqOp, reqSig, reqExp, outReady,
        input  reqReady, outValid, outSig, outExp, outV, outSrc, ovfCount
    );

endinterface

// File: rtl/fpu_norm_arbiter_normalizer.sv
// fpuNormalizer
// Combinational significand normalizer shared by the add/sub and mul paths.
//   op      in  operation (the shift/exponent behaviour is the same for all ops)
//   sig     in  extended significand, BIT_WIDTH-EXP_WIDTH bits
//   exp     in  adjusted exponent
//   normSig out normalized significand (leading one at bit SIG_WIDTH-1)
//   normExp out exponent corrected by the applied shift
//   v       out exponent overflow: MSB of the exponent changed across the correction
module fpuNormalizer
    import fpu_norm_arbiter_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int EXP_WIDTH = 5
) (
    input  fpuOp_t                         op,
    input  logic [BIT_WIDTH-EXP_WIDTH-1:0] sig,
    input  logic [EXP_WIDTH-1:0]           exp,
    output logic [BIT_WIDTH-EXP_WIDTH-1:0] normSig,
    output logic [EXP_WIDTH-1:0]           normExp,
    output logic                           v
);

    localparam int SW  = BIT_WIDTH - EXP_WIDTH - 1;
    localparam int LZW = $clog2(SW + 1);

    logic [LZW-1:0] lzc;
    logic           unused_op;

    // All ops normalize identically; op only keeps the requester port shape uniform.
    assign unused_op = ^op;

    // Leading zeros are counted over the low SW bits; the top bit is the
    // carry position that is handled by a right shift instead.
    always_comb begin
        lzc = '0;
        for (int i = 0; i < SW; i++) begin
            if (sig[i]) begin
                lzc = LZW'(SW - 1 - i);
            end
        end
    end

    always_comb begin
        normSig = '0;
        normExp = '0;
        if (sig == '0) begin
            normSig = '0;
            normExp = '0;
        end else if (sig[SW]) begin
            normSig = sig >> 1;
            normExp = exp + EXP_WIDTH'(1);
        end else begin
            normSig = sig << lzc;
            normExp = exp - EXP_WIDTH'(lzc);
        end
        v = exp[EXP_WIDTH-1] ^ normExp[EXP_WIDTH-1];
    end

endmodule

// File: rtl/fpu_norm_arbiter.sv
// fpu_norm_arbiter
// Round-robin arbiter sharing one fpuNormalizer between the add/sub requester
// (index 0) and the mul requester (index 1). The normalized result is held in
// a one-entry output stage tagged with its source, and a saturating counter
// tracks delivered results whose exponent overflowed.
//   clock  in  rising-edge clock
//   reset  in  asynchronous, active-high reset
//   bus    slave side of fpu_norm_arbiter_if (requests, result, ovfCount)
module fpu_norm_arbiter
    import fpu_norm_arbiter_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int EXP_WIDTH = 5,
    parameter int SIG_WIDTH = 10
) (
    input logic               clock,
    input logic               reset,
    fpu_norm_arbiter_if.slave bus
);

    logic                 stage_free;
    logic                 grant_any;
    logic                 transfer;
    logic                 sel_idx;
    normSrc_t             grant_src;

    fpuOp_t               mux_op;
    logic [SIG_WIDTH:0]   mux_sig;
    logic [EXP_WIDTH-1:0] mux_exp;
    logic [SIG_WIDTH:0]   norm_sig;
    logic [EXP_WIDTH-1:0] norm_exp;
    logic                 norm_v;

    logic                 out_valid_q,  out_valid_d;
    logic [SIG_WIDTH:0]   out_sig_q,    out_sig_d;
    logic [EXP_WIDTH-1:0] out_exp_q,    out_exp_d;
    logic                 out_v_q,      out_v_d;
    normSrc_t             out_src_q,    out_src_d;
    normSrc_t             last_grant_q, last_grant_d;
    logic [7:0]           ovf_count_q,  ovf_count_d;

    // Grant selection. Under contention the requester that did not win the
    // last transfer goes next. Readiness is suppressed while reset is held so
    // nothing is accepted during an asynchronous reset.
    always_comb begin
        stage_free = !reset && (!out_valid_q || bus.outReady);
        grant_any  = |bus.reqValid;
        if (bus.reqValid == 2'b11) begin
            grant_src = other_src(last_grant_q);
        end else if (bus.reqValid[1]) begin
            grant_src = SRC_MUL;
        end else begin
            grant_src = SRC_ADD;
        end
        transfer     = grant_any && stage_free;
        sel_idx      = (grant_src == SRC_MUL);
        bus.reqReady = 2'b00;
        if (transfer) begin
            bus.reqReady = sel_idx ? 2'b10 : 2'b01;
        end
    end

    assign mux_op  = bus.reqOp[sel_idx];
    assign mux_sig = bus.reqSig[sel_idx];
    assign mux_exp = bus.reqExp[sel_idx];

    fpuNormalizer #(
        .BIT_WIDTH (BIT_WIDTH),
        .EXP_WIDTH (EXP_WIDTH)
    ) u_normalizer (
        .op      (mux_op),
        .sig     (mux_sig),
        .exp     (mux_exp),
        .normSig (norm_sig),
        .normExp (norm_exp),
        .v       (norm_v)
    );

    // Output stage and counters. A pop and a transfer in the same cycle let
    // the new result overwrite the old one so valid stays high; a pop alone
    // only clears valid and leaves the data registers holding.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_sig_d    = out_sig_q;
        out_exp_d    = out_exp_q;
        out_v_d      = out_v_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        ovf_count_d  = ovf_count_q;

        if (out_valid_q && bus.outReady) begin
            out_valid_d = 1'b0;
            if (out_v_q && (ovf_count_q != OVF_COUNT_MAX)) begin
                ovf_count_d = ovf_count_q + 8'd1;
            end
        end

        if (transfer) begin
            out_valid_d  = 1'b1;
            out_sig_d    = norm_sig;
            out_exp_d    = norm_exp;
            out_v_d      = norm_v;
            out_src_d    = grant_src;
            last_grant_d = grant_src;
        end
    end

    // Pointer resets to the mul requester so add/sub wins the first contention.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_sig_q    <= '0;
            out_exp_q    <= '0;
            out_v_q      <= 1'b0;
            out_src_q    <= SRC_ADD;
            last_grant_q <= SRC_MUL;
            ovf_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_sig_q    <= out_sig_d;
            out_exp_q    <= out_exp_d;
            out_v_q      <= out_v_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign bus.outValid = out_valid_q;
    assign bus.outSig   = out_sig_q;
    assign bus.outExp   = out_exp_q;
    assign bus.outV     = out_v_q;
    assign bus.outSrc   = out_src_q;
    assign bus.ovfCount = ovf_count_q;

endmodule

// File: tb/tb_fpu_norm_arbiter.sv
// tb_fpu_norm_arbiter
// Scoreboard bench for fpu_norm_arbiter. Inputs are driven just after the
// falling edge and everything is sampled 1ns later, well away from the
// rising edge. Each accepted request pushes a model-normalized result; each
// pop is checked against the head of the queue.
module tb_fpu_norm_arbiter;
    import fpu_norm_arbiter_pkg::*;

    typedef struct {
        logic [10:0] sig;
        logic [4:0]  exp;
        logic        v;
        normSrc_t    src;
    } res_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    res_t        sb[$];
    logic        model_valid = 1'b0;
    normSrc_t    model_last  = SRC_MUL;
    logic [7:0]  model_count = 8'd0;
    logic [10:0] pend_sig [2];
    logic [4:0]  pend_exp [2];

    logic [1:0]  s_val [4] = '{2'b01, 2'b10, 2'b01, 2'b01};
    logic [10:0] s_sig [4] = '{11'h400, 11'h080, 11'h000, 11'h400};
    logic [4:0]  s_exp [4] = '{5'd10, 5'd15, 5'd3, 5'd15};
    logic [10:0] s_wsig[4] = '{11'h200, 11'h200, 11'h000, 11'h200};
    logic [4:0]  s_wexp[4] = '{5'd11, 5'd13, 5'd0, 5'd16};
    logic        s_wv  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    logic [1:0]  bp_val [8] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    logic        bp_rdy [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0]  bp_want[8] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};

    always #5 clock = ~clock;

    fpu_norm_arbiter_if #(.EXP_WIDTH(5), .SIG_WIDTH(10)) bus ();

    fpu_norm_arbiter #(
        .BIT_WIDTH (16),
        .EXP_WIDTH (5),
        .SIG_WIDTH (10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference normalizer: walks the leading one up to bit 9 one step at a time.
    function automatic res_t model_norm(input logic [10:0] s, input logic [4:0] e);
        res_t        r;
        logic [10:0] t;
        logic [4:0]  ne;
        t  = s;
        ne = e;
        if (s == 11'd0) begin
            t  = 11'd0;
            ne = 5'd0;
        end else if (s[10]) begin
            t  = s >> 1;
            ne = e + 5'd1;
        end else begin
            while (!t[9]) begin
                t  = t << 1;
                ne = ne - 5'd1;
            end
        end
        r.sig = t;
        r.exp = ne;
        r.v   = e[4] ^ ne[4];
        r.src = SRC_ADD;
        return r;
    endfunction

    function automatic logic [1:0] model_ready(input logic [1:0] v, input logic rdy);
        logic free;
        free = !model_valid || rdy;
        if (!free || v == 2'b00) return 2'b00;
        if (v == 2'b11) return (model_last == SRC_ADD) ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Applies one cycle of stimulus from the pending request data.
    task automatic applyStimulus(input logic [1:0] v, input logic rdy);
        @(negedge clock);
        bus.reqValid = v;
        bus.outReady = rdy;
        for (int i = 0; i < 2; i++) begin
            bus.reqSig[i] = pend_sig[i];
            bus.reqExp[i] = pend_exp[i];
        end
        #1;
    endtask

    // Advances the reference state across the coming rising edge.
    task automatic advance(input logic [1:0] ready, input logic rdy);
        res_t r;
        int   idx;
        if (model_valid && rdy) begin
            if (sb.size() > 0) begin
                if (sb[0].v && model_count != 8'hFF) model_count++;
                void'(sb.pop_front());
            end
            model_valid = 1'b0;
        end
        if (ready != 2'b00) begin
            idx   = ready[1] ? 1 : 0;
            r     = model_norm(pend_sig[idx], pend_exp[idx]);
            r.src = ready[1] ? SRC_MUL : SRC_ADD;
            sb.push_back(r);
            model_valid   = 1'b1;
            model_last    = r.src;
            pend_sig[idx] = 11'($urandom_range(0, 2047));
            pend_exp[idx] = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic test_reset();
        applyStimulus(2'b11, 1'b1);
        tests_run++;
        if (bus.reqReady !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset.ready: got %b, want 00", bus.reqReady);
        end
        tests_run++;
        if ({bus.outValid, bus.outSig, bus.outExp, bus.outV} !== 18'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset.out: got valid=%b sig=%h exp=%h v=%b, want all 0",
                     bus.outValid, bus.outSig, bus.outExp, bus.outV);
        end
        tests_run++;
        if (bus.outSrc !== SRC_ADD || bus.ovfCount !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset.src_count: got src=%0d count=%0d, want 0 0",
                     bus.outSrc, bus.ovfCount);
        end
        @(negedge clock);
        reset        = 1'b0;
        bus.reqValid = 2'b00;
    endtask

    task automatic test_contention();
        logic [1:0] want;
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i < 6) ? 2'b11 : 2'b00, 1'b1);
            want = (i >= 6) ? 2'b00 : (i[0] ? 2'b10 : 2'b01);
            tests_run++;
            if (bus.reqReady !== want) begin
                tests_failed++;
                $display("[TB] FAIL contention.ready[%0d]: got %b, want %b", i, bus.reqReady, want);
            end
            tests_run++;
            if (bus.outValid !== model_valid || bus.ovfCount !== model_count) begin
                tests_failed++;
                $display("[TB] FAIL contention.state[%0d]: got valid=%b count=%0d, want valid=%b count=%0d",
                         i, bus.outValid, bus.ovfCount, model_valid, model_count);
            end
            if (model_valid) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL contention.data[%0d]: got result, want empty scoreboard", i);
                end else if ({bus.outSig, bus.outExp, bus.outV, bus.outSrc} !==
                             {sb[0].sig, sb[0].exp, sb[0].v, sb[0].src}) begin
                    tests_failed++;
                    $display("[TB] FAIL contention.data[%0d]: got sig=%h exp=%h v=%b src=%0d, want sig=%h exp=%h v=%b src=%0d",
                             i, bus.outSig, bus.outExp, bus.outV, bus.outSrc,
                             sb[0].sig, sb[0].exp, sb[0].v, sb[0].src);
                end
            end
            advance(want, 1'b1);
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL contention.drain: got %0d left, want 0", sb.size());
        end
    endtask

    task automatic test_single();
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx           = s_val[k][1] ? 1 : 0;
            pend_sig[idx] = s_sig[k];
            pend_exp[idx] = s_exp[k];
            applyStimulus(s_val[k], 1'b1);
            tests_run++;
            if (bus.reqReady !== s_val[k]) begin
                tests_failed++;
                $display("[TB] FAIL single.ready[%0d]: got %b, want %b", k, bus.reqReady, s_val[k]);
            end
            advance(s_val[k], 1'b1);
            applyStimulus(2'b00, 1'b1);
            tests_run++;
            if ({bus.outValid, bus.outSig, bus.outExp, bus.outV, bus.outSrc} !==
                {1'b1, s_wsig[k], s_wexp[k], s_wv[k], normSrc_t'(idx)}) begin
                tests_failed++;
                $display("[TB] FAIL single.result[%0d]: got valid=%b sig=%h exp=%0d v=%b src=%0d, want valid=1 sig=%h exp=%0d v=%b src=%0d",
                         k, bus.outValid, bus.outSig, bus.outExp, bus.outV, bus.outSrc,
                         s_wsig[k], s_wexp[k], s_wv[k], idx);
            end
            advance(2'b00, 1'b1);
        end
        applyStimulus(2'b00, 1'b1);
        tests_run++;
        if (bus.outValid !== 1'b0 || bus.ovfCount !== model_count) begin
            tests_failed++;
            $display("[TB] FAIL single.after_pop: got valid=%b count=%0d, want valid=0 count=%0d",
                     bus.outValid, bus.ovfCount, model_count);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(bp_val[i], bp_rdy[i]);
            tests_run++;
            if (bus.reqReady !== bp_want[i]) begin
                tests_failed++;
                $display("[TB] FAIL backpressure.ready[%0d]: got %b, want %b", i, bus.reqReady, bp_want[i]);
            end
            tests_run++;
            if (bus.outValid !== model_valid || bus.ovfCount !== model_count) begin
                tests_failed++;
                $display("[TB] FAIL backpressure.state[%0d]: got valid=%b count=%0d, want valid=%b count=%0d",
                         i, bus.outValid, bus.ovfCount, model_valid, model_count);
            end
            if (model_valid) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL backpressure.data[%0d]: got result, want empty scoreboard", i);
                end else if ({bus.outSig, bus.outExp, bus.outV, bus.outSrc} !==
                             {sb[0].sig, sb[0].exp, sb[0].v, sb[0].src}) begin
                    tests_failed++;
                    $display("[TB] FAIL backpressure.data[%0d]: got sig=%h exp=%h v=%b src=%0d, want sig=%h exp=%h v=%b src=%0d",
                             i, bus.outSig, bus.outExp, bus.outV, bus.outSrc,
                             sb[0].sig, sb[0].exp, sb[0].v, sb[0].src);
                end
            end
            advance(bp_want[i], bp_rdy[i]);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] want;
        for (int i = 0; i <= 260; i++) begin
            pend_sig[0] = 11'h400;
            pend_exp[0] = 5'd15;
            applyStimulus((i < 260) ? 2'b01 : 2'b00, 1'b1);
            want = (i < 260) ? 2'b01 : 2'b00;
            tests_run++;
            if (bus.reqReady !== want || bus.ovfCount !== model_count) begin
                tests_failed++;
                $display("[TB] FAIL overflow.ready_count[%0d]: got ready=%b count=%0d, want ready=%b count=%0d",
                         i, bus.reqReady, bus.ovfCount, want, model_count);
            end
            if (model_valid) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL overflow.data[%0d]: got result, want empty scoreboard", i);
                end else if ({bus.outValid, bus.outSig, bus.outExp, bus.outV, bus.outSrc} !==
                             {1'b1, sb[0].sig, sb[0].exp, sb[0].v, sb[0].src}) begin
                    tests_failed++;
                    $display("[TB] FAIL overflow.data[%0d]: got valid=%b sig=%h exp=%0d v=%b, want valid=1 sig=%h exp=%0d v=%b",
                             i, bus.outValid, bus.outSig, bus.outExp, bus.outV,
                             sb[0].sig, sb[0].exp, sb[0].v);
                end
            end
            advance(want, 1'b1);
        end
        applyStimulus(2'b00, 1'b1);
        tests_run++;
        if (bus.ovfCount !== 8'd255 || bus.outValid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL overflow.saturate: got count=%0d valid=%b, want count=255 valid=0",
                     bus.ovfCount, bus.outValid);
        end
    endtask

    task automatic test_reset_midop();
        pend_sig[0] = 11'h400;
        pend_exp[0] = 5'd15;
        applyStimulus(2'b01, 1'b0);
        advance(2'b01, 1'b0);
        applyStimulus(2'b11, 1'b0);
        tests_run++;
        if (bus.outValid !== 1'b1 || bus.reqReady !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL midop.held: got valid=%b ready=%b, want valid=1 ready=00",
                     bus.outValid, bus.reqReady);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.outValid, bus.outSig, bus.outExp, bus.outV, bus.ovfCount} !== 26'd0 ||
            bus.outSrc !== SRC_ADD || bus.reqReady !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL midop.async_reset: got valid=%b sig=%h exp=%h v=%b count=%0d src=%0d ready=%b, want all 0",
                     bus.outValid, bus.outSig, bus.outExp, bus.outV, bus.ovfCount, bus.outSrc, bus.reqReady);
        end
        sb.delete();
        model_valid = 1'b0;
        model_last  = SRC_MUL;
        model_count = 8'd0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus.reqReady !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL midop.first_grant: got %b, want 01", bus.reqReady);
        end
        advance(2'b01, 1'b0);
        applyStimulus(2'b00, 1'b1);
        tests_run++;
        if (sb.size() == 0 || bus.outValid !== 1'b1 || bus.outSrc !== SRC_ADD ||
            {bus.outSig, bus.outExp, bus.outV} !== {sb[0].sig, sb[0].exp, sb[0].v}) begin
            tests_failed++;
            $display("[TB] FAIL midop.after_release: got valid=%b src=%0d sig=%h exp=%0d, want valid=1 src=0 and model result",
                     bus.outValid, bus.outSrc, bus.outSig, bus.outExp);
        end
        advance(2'b00, 1'b1);
        applyStimulus(2'b00, 1'b1);
        tests_run++;
        if (bus.outValid !== 1'b0 || bus.ovfCount !== model_count) begin
            tests_failed++;
            $display("[TB] FAIL midop.drain: got valid=%b count=%0d, want valid=0 count=%0d",
                     bus.outValid, bus.ovfCount, model_count);
        end
    endtask

    initial begin
        bus.reqValid  = 2'b11;
        bus.outReady  = 1'b1;
        bus.reqOp[0]  = OP_ADD;
        bus.reqOp[1]  = OP_MUL;
        for (int i = 0; i < 2; i++) begin
            pend_sig[i]   = 11'($urandom_range(0, 2047));
            pend_exp[i]   = 5'($urandom_range(0, 31));
            bus.reqSig[i] = 11'd0;
            bus.reqExp[i] = 5'd0;
        end
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_overflow();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
